plot_sequencer: RTL and testbench



---
 rtl/plot_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_plot_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sequencer.sv
// plot_sequencer: drives vga_adapter pixel writes. After reset or on request it
// sweeps the whole frame with the background colour, then draws one pixel per
// player from a frozen snapshot of the positions each time the game ticks.
module plot_sequencer #(
  parameter int unsigned X_MAX     = 160,
  parameter int unsigned Y_MAX     = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start_clear,
  input  logic        tick,
  input  logic [14:0] p1,
  input  logic [14:0] p2,
  input  logic [14:0] p3,
  input  logic [14:0] p4,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        clear_done
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_DRAW_P1,
    S_DRAW_P2,
    S_DRAW_P3,
    S_DRAW_P4
  } state_t;

  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);
  localparam logic [8:0] X_LIM  = 9'(X_MAX);
  localparam logic [7:0] Y_LIM  = 8'(Y_MAX);

  state_t      r_state;
  logic [7:0]  r_cx;
  logic [6:0]  r_cy;
  logic        r_pending;
  logic        r_sweep_end;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;
  logic        r_busy;
  logic        r_clear_done;

  state_t      w_state_next;
  logic [7:0]  w_cx_next;
  logic [6:0]  w_cy_next;
  logic        w_pending_next;
  logic        w_sweep_end_next;
  logic [7:0]  w_x_next;
  logic [6:0]  w_y_next;
  logic [2:0]  w_colour_next;
  logic        w_plot_next;
  logic        w_busy_next;
  logic        w_clear_done_next;
  logic        w_snap_load;

  logic [3:0][14:0] w_p_in;
  logic [3:0][14:0] w_snap;
  logic [1:0]       w_slot;
  logic [2:0]       w_draw_colour;
  logic [14:0]      w_pos;
  logic             w_in_range;
  logic [7:0]       w_sweep_cx;
  logic [6:0]       w_sweep_cy;

  assign w_p_in = {p4, p3, p2, p1};

  // One snapshot register per player, loaded only when a draw group launches
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      logic [14:0] r_pos;
      // Freeze this player's position at group launch
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          r_pos <= '0;
        end else if (w_snap_load) begin
          r_pos <= w_p_in[gi];
        end
      end
      assign w_snap[gi] = r_pos;
    end
  endgenerate

  // A clear request restarts the sweep from the origin on this very edge
  assign w_sweep_cx = start_clear ? '0 : r_cx;
  assign w_sweep_cy = start_clear ? '0 : r_cy;

  // Map the draw state to its player slot and colour
  always_comb begin
    w_slot        = 2'd0;
    w_draw_colour = 3'b001;
    case (r_state)
      S_DRAW_P2: begin w_slot = 2'd1; w_draw_colour = 3'b010; end
      S_DRAW_P3: begin w_slot = 2'd2; w_draw_colour = 3'b100; end
      S_DRAW_P4: begin w_slot = 2'd3; w_draw_colour = 3'b110; end
      default:   begin w_slot = 2'd0; w_draw_colour = 3'b001; end
    endcase
  end

  assign w_pos      = w_snap[w_slot];
  assign w_in_range = ({1'b0, w_pos[14:7]} < X_LIM) && ({1'b0, w_pos[6:0]} < Y_LIM);

  // Next-state and next-output logic; outputs are registered from these
  always_comb begin
    w_state_next      = r_state;
    w_cx_next         = r_cx;
    w_cy_next         = r_cy;
    w_pending_next    = r_pending;
    w_sweep_end_next  = 1'b0;
    w_snap_load       = 1'b0;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_colour_next     = r_colour;
    w_plot_next       = 1'b0;
    w_busy_next       = (r_state != S_IDLE) || start_clear;
    w_clear_done_next = r_sweep_end;

    if (start_clear || (r_state == S_CLEAR)) begin
      // Sweep step: emit current pixel, advance raster counters
      w_state_next   = S_CLEAR;
      w_pending_next = 1'b0;
      w_x_next       = w_sweep_cx;
      w_y_next       = w_sweep_cy;
      w_colour_next  = BG_COLOUR;
      w_plot_next    = 1'b1;
      if (w_sweep_cx == X_LAST) begin
        w_cx_next = '0;
        if (w_sweep_cy == Y_LAST) begin
          w_cy_next        = '0;
          w_state_next     = S_IDLE;
          w_sweep_end_next = 1'b1;
        end else begin
          w_cy_next = w_sweep_cy + 7'd1;
        end
      end else begin
        w_cx_next = w_sweep_cx + 8'd1;
      end
    end else if (r_state == S_IDLE) begin
      if (tick) begin
        w_snap_load  = 1'b1;
        w_state_next = S_DRAW_P1;
      end
    end else begin
      // Off-screen positions burn their slot without writing
      if (w_in_range) begin
        w_x_next      = w_pos[14:7];
        w_y_next      = w_pos[6:0];
        w_colour_next = w_draw_colour;
        w_plot_next   = 1'b1;
      end
      case (r_state)
        S_DRAW_P1: begin w_state_next = S_DRAW_P2; w_pending_next = r_pending | tick; end
        S_DRAW_P2: begin w_state_next = S_DRAW_P3; w_pending_next = r_pending | tick; end
        S_DRAW_P3: begin w_state_next = S_DRAW_P4; w_pending_next = r_pending | tick; end
        default: begin
          if (r_pending || tick) begin
            w_pending_next = 1'b0;
            w_snap_load    = 1'b1;
            w_state_next   = S_DRAW_P1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_CLEAR;
      r_cx         <= '0;
      r_cy         <= '0;
      r_pending    <= 1'b0;
      r_sweep_end  <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= BG_COLOUR;
      r_plot       <= 1'b0;
      r_busy       <= 1'b1;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cx         <= w_cx_next;
      r_cy         <= w_cy_next;
      r_pending    <= w_pending_next;
      r_sweep_end  <= w_sweep_end_next;
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_colour     <= w_colour_next;
      r_plot       <= w_plot_next;
      r_busy       <= w_busy_next;
      r_clear_done <= w_clear_done_next;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_plot_sequencer.sv
// Testbench for plot_sequencer: scoreboard of expected pixel writes, popped
// and compared by a monitor whenever the DUT asserts plot.
module tb_plot_sequencer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_clear = 1'b0;
  logic        tick = 1'b0;
  logic [14:0] p1 = '0;
  logic [14:0] p2 = '0;
  logic [14:0] p3 = '0;
  logic [14:0] p4 = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        clear_done;

  int   total = 0;
  int   bad = 0;
  pix_t exp_q[$];

  plot_sequencer dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .start_clear(start_clear),
    .tick       (tick),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input int px, input int py);
    return {px[7:0], py[6:0]};
  endfunction

  task automatic push_pix(input int px, input int py, input logic [2:0] c);
    pix_t e;
    e.x = px[7:0];
    e.y = py[6:0];
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int n);
    for (int k = 0; k < n; k++) push_pix(k % 160, k / 160, 3'b000);
  endtask

  task automatic push_group(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, input int dx, input int dy);
    push_pix(ax, ay, 3'b001);
    push_pix(bx, by, 3'b010);
    push_pix(cx, cy, 3'b100);
    push_pix(dx, dy, 3'b110);
  endtask

  // Scoreboard monitor: every write must match the next expected pixel
  always @(negedge clk) begin
    if (!rst && plot) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%b), required no plot", x, y, colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if ({x, y, colour} !== {e.x, e.y, e.c}) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d,%b), required (%0d,%0d,%b)",
                   x, y, colour, e.x, e.y, e.c);
        end else if (colour != 3'b000) begin
          $display("write (%0d,%0d,%b)", x, y, colour);
        end
      end
    end
  end

  task automatic test_reset;
    #1 rst = 1'b1;
    #3;
    total++;
    if ({plot, busy, clear_done} !== 3'b010) begin
      bad++;
      $display("FAIL reset_flags: got plot/busy/done=%b, required 010", {plot, busy, clear_done});
    end
    total++;
    if ({x, y, colour} !== 18'd0) begin
      bad++;
      $display("FAIL reset_pixel: got (%0d,%0d,%b), required (0,0,000)", x, y, colour);
    end
    $display("reset checked");
  endtask

  task automatic test_clear_sweep;
    int n;
    push_clear(19200);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clear_done && n < 19400);
    total++;
    if (n !== 19201) begin
      bad++;
      $display("FAIL clear_done_time: got edge count %0d, required 19201", n);
    end
    total++;
    if ({busy, plot} !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL sweep_end: got busy=%b plot=%b left=%0d, required 0 0 0",
               busy, plot, exp_q.size());
    end
    @(negedge clk);
    total++;
    if (clear_done !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_pulse: got %b, required 0", clear_done);
    end
    $display("clear sweep checked");
  endtask

  task automatic test_group;
    p1 = pk(10, 20); p2 = pk(30, 40); p3 = pk(50, 60); p4 = pk(70, 80);
    push_group(10, 20, 30, 40, 50, 60, 70, 80);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    p1 = pk(5, 5);
    total++;
    if (plot !== 1'b0) begin
      bad++;
      $display("FAIL group_latency: got plot=%b after tick edge, required 0", plot);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++;
      if (plot !== 1'b1) begin
        bad++;
        $display("FAIL group_slot%0d: got plot=%b, required 1", i, plot);
      end
    end
    @(negedge clk);
    total++;
    if ({plot, busy} !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL group_end: got plot=%b busy=%b left=%0d, required 0 0 0",
               plot, busy, exp_q.size());
    end
    $display("single group checked");
  endtask

  task automatic test_back_to_back;
    p1 = pk(10, 20);
    push_group(10, 20, 30, 40, 50, 60, 70, 80);
    push_group(10, 20, 30, 40, 50, 60, 70, 80);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    for (int i = 4; i <= 8; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if ({plot, busy} !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end: got plot=%b busy=%b left=%0d, required 0 0 0",
               plot, busy, exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("back to back checked");
  endtask

  task automatic test_out_of_range;
    p3 = pk(200, 10);
    push_pix(10, 20, 3'b001);
    push_pix(30, 40, 3'b010);
    push_pix(70, 80, 3'b110);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({plot, x, y, colour} !== {1'b0, 8'd30, 7'd40, 3'b010}) begin
      bad++;
      $display("FAIL oor_slot: got plot=%b (%0d,%0d,%b), required 0 (30,40,010)",
               plot, x, y, colour);
    end
    @(negedge clk);
    total++;
    if (plot !== 1'b1) begin
      bad++;
      $display("FAIL oor_p4: got plot=%b, required 1", plot);
    end
    @(negedge clk);
    total++;
    if ({plot, busy} !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL oor_end: got plot=%b busy=%b left=%0d, required 0 0 0",
               plot, busy, exp_q.size());
    end
    $display("out of range checked");
  endtask

  task automatic test_clear_priority;
    int n;
    p3 = pk(50, 60);
    push_pix(10, 20, 3'b001);
    push_pix(30, 40, 3'b010);
    push_clear(19200);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_clear = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    start_clear = 1'b0;
    tick = 1'b0;
    total++;
    if ({plot, x, y, colour} !== {1'b1, 18'd0}) begin
      bad++;
      $display("FAIL clear_priority: got plot=%b (%0d,%0d,%b), required 1 (0,0,000)",
               plot, x, y, colour);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clear_done && n < 19400);
    total++;
    if (n !== 19200) begin
      bad++;
      $display("FAIL restart_done_time: got %0d cycles, required 19200", n);
    end
    repeat (6) @(negedge clk);
    total++;
    if ({plot, busy} !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_dropped: got plot=%b busy=%b left=%0d, required 0 0 0",
               plot, busy, exp_q.size());
    end
    $display("clear priority checked");
  endtask

  task automatic test_reset_mid;
    int n;
    push_clear(5001);
    start_clear = 1'b1;
    @(negedge clk);
    start_clear = 1'b0;
    repeat (5000) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({plot, busy, clear_done} !== 3'b010 || {x, y, colour} !== 18'd0) begin
      bad++;
      $display("FAIL mid_reset: got plot/busy/done=%b (%0d,%0d,%b), required 010 (0,0,000)",
               {plot, busy, clear_done}, x, y, colour);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_count: got %0d pixels left, required 0", exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    push_clear(19200);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clear_done && n < 19400);
    total++;
    if (n !== 19201 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_resweep: got edges=%0d left=%0d, required 19201 0", n, exp_q.size());
    end
    $display("mid-sweep reset checked");
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_group();
    test_back_to_back();
    test_out_of_range();
    test_clear_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
